// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit
//  Purpose  : LEGv8 instruction-fetch stage. Owns the program counter,
//             presents it as the byte address to a combinational instruction
//             memory, captures the returned word into the IF/ID register and
//             selects the next PC. Unconditional B/BL are predecoded and
//             taken here; every other control-flow change arrives from the
//             downstream branch-resolution logic as a redirect.
//
//  Parameters
//    RESET_PC        PC value loaded while reset is asserted
//    IMEM_BYTES      instruction memory size in bytes (power of two, > 4)
//
//  Ports
//    clk             system clock, rising-edge active
//    reset           asynchronous, active-low; 0 clears all state at once
//    imem_addr       byte address to instruction memory (the PC register)
//    imem_instr      instruction word returned combinationally for imem_addr
//    stall           hazard hold: PC and IF/ID keep their values
//    redirect        branch resolved taken/mispredicted: flush and reload PC
//    redirect_target new PC when redirect = 1
//    id_valid        IF/ID holds a real instruction
//    id_instr        captured instruction word
//    id_pc           PC of the captured instruction
//    id_pred_taken   captured instruction was a B/BL already taken in fetch
//    fetch_fault     sticky: PC misaligned or out of range, fetch halted
//
//  Revision : 1.0  initial release
// ============================================================================
module fetch_unit #(
    parameter logic [63:0] RESET_PC   = 64'd0,
    parameter int          IMEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    output logic [63:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        stall,
    input  logic        redirect,
    input  logic [63:0] redirect_target,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [63:0] id_pc,
    output logic        id_pred_taken,
    output logic        fetch_fault
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [63:0] c_imem_bytes = 64'(IMEM_BYTES);
    localparam logic [5:0]  c_op_b       = 6'b000101;
    localparam logic [5:0]  c_op_bl      = 6'b100101;

    typedef enum logic [0:0] {
        S_RUN   = 1'b0,
        S_FAULT = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t      r_state;
    logic [63:0] r_pc;
    logic        r_id_valid;
    logic [31:0] r_id_instr;
    logic [63:0] r_id_pc;
    logic        r_id_pred_taken;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic        w_pc_legal;
    logic        w_is_b;
    logic [63:0] w_br_offset;
    logic [63:0] w_br_target;
    logic [63:0] w_pc_plus4;

    // With pc[1:0] == 0 the sum pc + 3 cannot wrap, so the plain 64-bit
    // compare is exact for every aligned PC.
    assign w_pc_legal  = (r_pc[1:0] == 2'b00) && ((r_pc + 64'd3) < c_imem_bytes);

    assign w_is_b      = (imem_instr[31:26] == c_op_b) || (imem_instr[31:26] == c_op_bl);

    // imm26 is a word offset: sign-extend and scale by 4 in one concatenation.
    assign w_br_offset = {{36{imem_instr[25]}}, imem_instr[25:0], 2'b00};
    assign w_br_target = r_pc + w_br_offset;
    assign w_pc_plus4  = r_pc + 64'd4;

    // ------------------------------------------------------------------
    // Fetch state machine and IF/ID register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state         <= S_RUN;
            r_pc            <= RESET_PC;
            r_id_valid      <= 1'b0;
            r_id_instr      <= 32'd0;
            r_id_pc         <= 64'd0;
            r_id_pred_taken <= 1'b0;
        end else if (r_state == S_RUN) begin
            if (redirect) begin
                // Redirect wins over stall and over an illegal PC; the
                // slot being fetched this cycle is on the wrong path.
                r_pc            <= redirect_target;
                r_id_valid      <= 1'b0;
                r_id_pred_taken <= 1'b0;
            end else if (stall) begin
                r_pc            <= r_pc;
            end else if (!w_pc_legal) begin
                // PC holds so the offending address stays visible.
                r_state         <= S_FAULT;
                r_id_valid      <= 1'b0;
            end else begin
                r_id_instr      <= imem_instr;
                r_id_pc         <= r_pc;
                r_id_valid      <= 1'b1;
                r_id_pred_taken <= w_is_b;
                r_pc            <= w_is_b ? w_br_target : w_pc_plus4;
            end
        end else begin
            // Fault is terminal until reset; everything freezes with the
            // IF/ID slot marked empty.
            r_id_valid <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Outputs (all straight from registers)
    // ------------------------------------------------------------------
    assign imem_addr     = r_pc;
    assign id_valid      = r_id_valid;
    assign id_instr      = r_id_instr;
    assign id_pc         = r_id_pc;
    assign id_pred_taken = r_id_pred_taken;
    assign fetch_fault   = (r_state == S_FAULT);

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_unit
//  Purpose  : Self-checking bench for fetch_unit. A directed walk through
//             the main scenarios is followed by randomized stall / redirect /
//             reset traffic over randomly filled memory, all checked each
//             cycle against a behavioural model of the fetch rules.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch_unit;

    localparam int          IMEM   = 1024;
    localparam logic [63:0] RST_PC = 64'd0;
    localparam logic [31:0] ADDI   = 32'h9100_0421;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] imem_addr;
    logic [31:0] imem_instr;
    logic        stall;
    logic        redirect;
    logic [63:0] redirect_target;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [63:0] id_pc;
    logic        id_pred_taken;
    logic        fetch_fault;

    logic [31:0] mem [256];

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    logic [63:0] m_pc;
    logic        m_valid;
    logic [31:0] m_instr;
    logic [63:0] m_idpc;
    logic        m_pred;
    logic        m_fault;

    fetch_unit #(.RESET_PC(RST_PC), .IMEM_BYTES(IMEM)) dut (
        .clk             (clk),
        .reset           (reset),
        .imem_addr       (imem_addr),
        .imem_instr      (imem_instr),
        .stall           (stall),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .id_valid        (id_valid),
        .id_instr        (id_instr),
        .id_pc           (id_pc),
        .id_pred_taken   (id_pred_taken),
        .fetch_fault     (fetch_fault)
    );

    always #5 clk = ~clk;

    // Out-of-range addresses read as all-ones (opcode 111111, never a branch).
    assign imem_instr = (imem_addr < 64'(IMEM)) ? mem[imem_addr[9:2]] : 32'hFFFF_FFFF;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        if (a < 64'(IMEM)) return mem[a[9:2]];
        return 32'hFFFF_FFFF;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        check("imem_addr",     imem_addr,     m_pc);
        check("id_valid",      64'(id_valid), 64'(m_valid));
        check("id_instr",      64'(id_instr), 64'(m_instr));
        check("id_pc",         id_pc,         m_idpc);
        check("id_pred_taken", 64'(id_pred_taken), 64'(m_pred));
        check("fetch_fault",   64'(fetch_fault),   64'(m_fault));
    endtask

    task automatic model_reset();
        m_pc = RST_PC; m_valid = 0; m_instr = 0; m_idpc = 0; m_pred = 0; m_fault = 0;
    endtask

    // One clock of the fetch rules, in priority order.
    task automatic model_step(input logic s, input logic r, input logic [63:0] t);
        logic [31:0]        w;
        logic signed [25:0] imm;
        longint             off;
        if (m_fault) return;
        if (r) begin
            m_pc = t; m_valid = 0; m_pred = 0;
        end else if (s) begin
            // hold
        end else if (!(m_pc % 4 == 0 && m_pc <= 64'(IMEM - 4))) begin
            m_fault = 1; m_valid = 0;
        end else begin
            w       = mem_word(m_pc);
            m_instr = w;
            m_idpc  = m_pc;
            m_valid = 1;
            m_pred  = (w[31:26] == 6'd5) || (w[31:26] == 6'd37);
            if (m_pred) begin
                imm  = w[25:0];
                off  = imm;
                m_pc = m_pc + 64'(off * 4);
            end else begin
                m_pc = m_pc + 64'd4;
            end
        end
    endtask

    // Called at a falling edge: apply inputs, clock once, compare at the next
    // falling edge.
    task automatic step(input logic s, input logic r, input logic [63:0] t);
        stall = s; redirect = r; redirect_target = t;
        model_step(s, r, t);
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    // Asynchronous reset pulse placed between edges.
    task automatic reset_pulse();
        reset = 1'b0;
        #1;
        model_reset();
        check_all();
        #1;
        reset = 1'b1;
    endtask

    initial begin
        logic [63:0] tgt;
        int          k;
        reset = 1'b0; stall = 0; redirect = 0; redirect_target = 0;
        for (int i = 0; i < 256; i++) mem[i] = ADDI;
        mem[4]  = 32'h17FF_FFFE;   // pc 16: B imm26 = -2  -> 8
        mem[10] = 32'h1400_0003;   // pc 40: B imm26 = 3   -> 52
        model_reset();
        @(negedge clk);
        check_all();
        check("rst_addr", imem_addr, 64'd0);
        reset = 1'b1;

        // sequential fetch
        step(0, 0, 0);
        check("seq_idpc0", id_pc, 64'd0);
        step(0, 0, 0);
        step(0, 0, 0);
        check("seq_addr12", imem_addr, 64'd12);
        check("seq_idpc8",  id_pc, 64'd8);
        // stall two cycles at pc 12
        step(1, 0, 0);
        step(1, 0, 0);
        check("stall_addr", imem_addr, 64'd12);
        check("stall_idpc", id_pc, 64'd8);
        step(0, 0, 0);
        check("rel_addr", imem_addr, 64'd16);
        // backward B at pc 16
        step(0, 0, 0);
        check("bneg_addr", imem_addr, 64'd8);
        check("bneg_pred", 64'(id_pred_taken), 64'd1);
        // redirect under stall to 40, then forward B at 40
        step(1, 1, 64'd40);
        check("redir_addr",  imem_addr, 64'd40);
        check("redir_valid", 64'(id_valid), 64'd0);
        step(0, 0, 0);
        check("bpos_addr", imem_addr, 64'd52);
        check("bpos_idpc", id_pc, 64'd40);
        // misaligned redirect, fault, ignored redirect
        step(0, 1, 64'd42);
        step(0, 0, 0);
        check("mis_fault", 64'(fetch_fault), 64'd1);
        step(0, 1, 64'd0);
        check("fault_hold", imem_addr, 64'd42);
        reset_pulse();
        step(0, 0, 0);
        // last legal word, then first address past the end
        step(0, 1, 64'd1020);
        step(0, 0, 0);
        check("edge_idpc", id_pc, 64'd1020);
        step(0, 0, 0);
        check("edge_fault", 64'(fetch_fault), 64'd1);
        reset_pulse();

        // randomized traffic
        for (int i = 0; i < 256; i++) begin
            if ($urandom_range(0, 9) < 3) begin
                k      = int'($urandom_range(0, 127)) - 64;
                mem[i] = {($urandom_range(0, 1) != 0) ? 6'b000101 : 6'b100101, 26'(k)};
            end else begin
                mem[i] = $urandom;
            end
        end
        for (int c = 0; c < 3000; c++) begin
            if (m_fault && $urandom_range(0, 3) == 0) begin
                reset_pulse();
            end else if ($urandom_range(0, 99) == 0) begin
                reset_pulse();
            end
            k = int'($urandom_range(0, 99));
            if (k < 3)       tgt = {$urandom, $urandom};
            else if (k < 6)  tgt = 64'($urandom_range(0, 1023));
            else             tgt = {54'd0, 8'($urandom_range(0, 255)), 2'b00};
            step($urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0, tgt);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
